// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver.
// Synchronizes and deglitches the raw PS/2 lines and deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop). It folds the 0xE0 and 0xF0
// prefixes into the is_ext and is_break flags that accompany the next code byte.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
//
// Handshake: scan_valid is a one-cycle strobe with no ready. scan_code,
// is_break and is_ext are meaningful in the strobe cycle and hold until the
// next strobe. frame_err is a one-cycle strobe and never coincides with
// scan_valid.
`timescale 1ns/1ps

module ps2_scan_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err,
    output logic [1:0] dbg_state
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          clk_meta;
    logic          clk_s;
    logic          data_meta;
    logic          data_s;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          sample_ev;

    logic [TW-1:0] timer;
    logic          timeout;

    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_bit;
    logic          parity_ok;
`endif

    logic          stop_ev;
    logic          frame_bad;
    logic          byte_good;
    logic          err_now;
    logic          brk_flag;
    logic          ext_flag;

    assign dbg_state = state;

    // Two-flop synchronizers on both raw lines. They reset to the idle-high bus level.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_s     <= 1'b1;
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_s     <= clk_meta;
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    // Deglitch filter: the filtered clock flips on the FILTER_LEN-th consecutive
    // sample that differs from it. Any sample equal to it restarts the count.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // The sample event is the cycle in which the filtered clock is about to fall.
    // data_s is sampled in that same cycle.
    assign sample_ev = filt_clk && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));

    // Inter-edge watchdog. It runs only inside a frame and restarts on every sample event.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            timer <= '0;
        end else if (state == IDLE || sample_ev || timeout) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !sample_ev && (timer == TW'(TIMEOUT_CYC - 1));

    // FSM state register
    always_ff @(posedge board_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (sample_ev) begin
            case (state)
                IDLE:    if (!data_s) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM output decode: classify the byte that is finishing on the stop sample.
    always_comb begin
        stop_ev   = sample_ev && (state == STOP);
`ifdef PS2_PARITY_CHECK_EN
        parity_ok = ^{shift, parity_bit};
        frame_bad = stop_ev && (!data_s || !parity_ok);
`else
        frame_bad = stop_ev && !data_s;
`endif
        byte_good = stop_ev && !frame_bad;
        err_now   = timeout || frame_bad;
    end

    // Bit shifter: LSB first into the top of the register. A timeout discards the partial byte.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            shift      <= '0;
            bit_cnt    <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= 1'b0;
`endif
        end else if (timeout) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (sample_ev) begin
            case (state)
                IDLE: bit_cnt <= '0;
                DATA: begin
                    shift   <= {data_s, shift[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
`ifdef PS2_PARITY_CHECK_EN
                PARITY: parity_bit <= data_s;
`endif
                default: ;
            endcase
        end
    end

    // Prefix tracking and registered output strobes. They appear the cycle after the stop sample.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            frame_err  <= 1'b0;
            brk_flag   <= 1'b0;
            ext_flag   <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (err_now) begin
                frame_err <= 1'b1;
                brk_flag  <= 1'b0;
                ext_flag  <= 1'b0;
            end else if (byte_good) begin
                if (shift == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    scan_code  <= shift;
                    is_break   <= brk_flag;
                    is_ext     <= ext_flag;
                    scan_valid <= 1'b1;
                    brk_flag   <= 1'b0;
                    ext_flag   <= 1'b0;
                end
            end
        end
    end

endmodule
